// File: rtl/pdp1_ptp.sv
// pdp1_ptp: PDP-1 paper tape punch. Decodes ppa/ppb IOTs into 8-bit frames queued in a first-word-fall-through FIFO for a host byte stream.
// A frame is visible one edge after its push, and a full FIFO stalls the CPU via bs_inh. Define PDP1_PTP_STATUS_EN to add the o033 status read.
module pdp1_ptp #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        bs_stb,
  input  logic [0:10] bs_adr,
  input  logic        bs_wait,
  input  logic [0:17] bs_din,
  output logic [0:17] bs_dout,
  output logic        bs_inh,
  output logic [7:0]  o_pch_data,
  output logic        o_pch_valid,
  input  logic        i_pch_ready,
  output logic        o_empty,
  output logic        o_flag
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          is_ppa;
  logic          is_ppb;
  logic          push;
  logic          pop;
  logic [7:0]    frame;

  assign is_ppa = (bs_adr == 11'o005);
  assign is_ppb = (bs_adr == 11'o006);
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);

  // Binary mode forces channel 8 and clears channel 7 so the tape reader can tell the frame types apart.
  assign frame  = is_ppb ? {2'b10, bs_din[0:5]} : bs_din[10:17];

  assign push   = bs_stb & (is_ppa | is_ppb) & ~full;
  assign pop    = ~empty & i_pch_ready;
  assign bs_inh = bs_stb & (is_ppa | is_ppb) & full;

  assign o_pch_data  = mem[rd_ptr];
  assign o_pch_valid = ~empty;
  assign o_empty     = empty;
  assign o_flag      = ~full;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= frame;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PDP1_PTP_STATUS_EN
  logic [0:17] status;
  logic        is_stat;
  logic        unused_ok;

  assign is_stat = (bs_adr == 11'o033);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                status <= '0;
    else if (bs_stb & is_stat) status <= {full, empty, 10'b0, 6'(count)};
  end

  assign bs_dout   = (is_stat & bs_wait) ? status : 'z;
  assign unused_ok = &{1'b0, bs_din[6:9]};
`else
  logic unused_ok;

  assign bs_dout   = 'z;
  assign unused_ok = &{1'b0, bs_wait, bs_din[6:9]};
`endif

endmodule

// File: tb/tb_pdp1_ptp.sv
// Scoreboard bench for pdp1_ptp: stimulus pushes expected frames, a negedge monitor checks the stream and status flags.
module tb_pdp1_ptp;
  localparam int DEPTH = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        bs_stb = 1'b0;
  logic [0:10] bs_adr = '0;
  logic        bs_wait = 1'b0;
  logic [0:17] bs_din = '0;
  wire  [0:17] bs_dout;
  logic        bs_inh;
  logic [7:0]  o_pch_data;
  logic        o_pch_valid;
  logic        i_pch_ready = 1'b0;
  logic        o_empty;
  logic        o_flag;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  sb[$];
  int          pop_cnt = 0;
  int          pop_seen = 0;
  int          ready_mode = 0;  // 0 low, 1 high, 2 random

  pdp1_ptp #(.DEPTH(DEPTH), .AW(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bs_stb(bs_stb), .bs_adr(bs_adr),
    .bs_wait(bs_wait), .bs_din(bs_din), .bs_dout(bs_dout), .bs_inh(bs_inh),
    .o_pch_data(o_pch_data), .o_pch_valid(o_pch_valid), .i_pch_ready(i_pch_ready),
    .o_empty(o_empty), .o_flag(o_flag)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready driver: updates just after each rising edge.
  initial forever begin
    @(posedge i_clk);
    #1;
    case (ready_mode)
      1:       i_pch_ready = 1'b1;
      2:       i_pch_ready = ($urandom_range(0, 3) != 0);
      default: i_pch_ready = 1'b0;
    endcase
  end

  // Pops decided at a falling edge take effect at the next rising edge.
  always @(posedge i_clk) pop_seen = pop_cnt;

  // Monitor: occupancy of the model queue equals the DUT's FIFO count at every falling edge.
  always @(negedge i_clk) begin
    int n;
    if (i_rst) begin
      n = sb.size();
      check("valid", o_pch_valid, n != 0);
      check("empty", o_empty, n == 0);
      check("flag", o_flag, n != DEPTH);
`ifndef PDP1_PTP_STATUS_EN
      check("dout_z", bs_dout === 18'bz, 1);
`endif
      if (o_pch_valid && i_pch_ready && n != 0) begin
        check("data", o_pch_data, sb[0]);
        void'(sb.pop_front());
        pop_cnt++;
      end
    end
  end

  function automatic logic [7:0] frame_of(input logic [10:0] adr, input logic [17:0] din);
    if (adr == 11'o006) return 8'h80 | 8'(din >> 12);
    return 8'(din % 256);
  endfunction

  // Issue one IOT, holding the strobe while the model says the FIFO is full.
  task automatic iot(input logic [10:0] adr, input logic [17:0] din);
    bit dec;
    bit full_m;
    int guard;
    dec = (adr == 11'o005) || (adr == 11'o006);
    guard = 0;
    @(negedge i_clk);
    #2;
    bs_adr = adr;
    bs_din = din;
    bs_stb = 1'b1;
    forever begin
      #1;
      full_m = (sb.size() + (pop_cnt - pop_seen)) == DEPTH;
      check("inh", bs_inh, dec && full_m);
      @(posedge i_clk);
      if (!dec) break;
      if (!full_m) begin
        sb.push_back(frame_of(adr, din));
        break;
      end
      guard++;
      if (guard > 200) begin
        checks++;
        failures++;
        $display("FAIL stall_timeout actual=stuck required=accepted at %0t", $time);
        break;
      end
      @(negedge i_clk);
      #2;
    end
    #1;
    bs_stb = 1'b0;
    bs_adr = '0;
  endtask

  task automatic drain();
    int k;
    ready_mode = 1;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge i_clk);
      k++;
    end
    check("drained", sb.size(), 0);
    ready_mode = 0;
    repeat (2) @(posedge i_clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [10:0] adr;
    logic [17:0] din;
    int r;

    // Reset state
    #2;
    check("rst_valid", o_pch_valid, 0);
    check("rst_empty", o_empty, 1);
    check("rst_flag", o_flag, 1);
    check("rst_inh", bs_inh, 0);
    check("rst_dout_z", bs_dout === 18'bz, 1);
    repeat (2) @(negedge i_clk);
    #2 i_rst = 1'b1;

    // Alphanumeric frame
    iot(11'o005, 18'o000123);
    @(negedge i_clk);
    check("t1_data", o_pch_data, 8'h53);
    check("t1_valid", o_pch_valid, 1);
    check("t1_flag", o_flag, 1);
    drain();

    // Binary frame
    iot(11'o006, 18'o570000);
    @(negedge i_clk);
    check("t2_data", o_pch_data, 8'hAF);
    drain();

    // Fill, stall, single pop releases the stall
    for (int i = 0; i < DEPTH; i++) iot(11'o005, 18'(i));
    @(negedge i_clk);
    check("t3_flag", o_flag, 0);
    fork
      iot(11'o005, 18'h011);
      begin
        repeat (3) @(posedge i_clk);
        #2 ready_mode = 1;
        @(posedge i_clk);
        #2 ready_mode = 0;
      end
    join
    check("t3_tail", sb[sb.size()-1], 8'h11);
    drain();

    // Streaming with ready held high, across several pointer wraps
    ready_mode = 1;
    repeat (2) @(posedge i_clk);
    for (int i = 0; i < 40; i++) iot(11'o005, (i % 2 == 0) ? 18'h0AA : 18'h055);
    drain();

    // Randomized mix of punch IOTs, foreign addresses and host backpressure
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      din = 18'($urandom);
      if (r < 4)      adr = 11'o005;
      else if (r < 8) adr = 11'o006;
      else begin
        adr = 11'($urandom_range(0, 2047));
        if (adr == 11'o005 || adr == 11'o006 || adr == 11'o033) adr = 11'o077;
      end
      iot(adr, din);
    end
    drain();

    // Reset asserted during a stall
    for (int i = 0; i < DEPTH; i++) iot(11'o006, 18'($urandom));
    @(negedge i_clk);
    #2;
    bs_adr = 11'o005;
    bs_din = 18'h022;
    bs_stb = 1'b1;
    #1;
    check("t5_inh_before", bs_inh, 1);
    i_rst = 1'b0;
    sb.delete();
    #1;
    check("t5_inh", bs_inh, 0);
    check("t5_valid", o_pch_valid, 0);
    check("t5_empty", o_empty, 1);
    check("t5_flag", o_flag, 1);
    check("t5_dout_z", bs_dout === 18'bz, 1);
    bs_stb = 1'b0;
    bs_adr = '0;
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    iot(11'o005, 18'h033);
    @(negedge i_clk);
    check("t5_fresh", o_pch_data, 8'h33);
    drain();

    // Status read
    for (int i = 0; i < 3; i++) iot(11'o005, 18'(8'hC0 + i));
    @(negedge i_clk);
    #2;
    bs_adr = 11'o033;
    bs_wait = 1'b1;
    bs_stb = 1'b1;
    @(posedge i_clk);
    #1;
`ifdef PDP1_PTP_STATUS_EN
    check("t6_status", bs_dout,
          ((sb.size() == DEPTH) ? 32'h20000 : 32'h0) |
          ((sb.size() == 0) ? 32'h10000 : 32'h0) | 32'(sb.size()));
`else
    check("t6_dout_z", bs_dout === 18'bz, 1);
`endif
    bs_wait = 1'b0;
    #1;
    check("t6_dout_z_nowait", bs_dout === 18'bz, 1);
    bs_stb = 1'b0;
    bs_adr = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
